// File: rtl/sec_min_display_mux.sv
// MM:SS four-digit common-anode seven-segment scanner with frame snapshot.
// Ports: clk/reset in; BCD digits, blank, lz_blank in; an, seg, dp out (active-low).
module sec_min_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] secUnits,
  input  logic [2:0] secTens,
  input  logic [3:0] minUnits,
  input  logic [2:0] minTens,
  input  logic       blank,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] rc;
  logic [1:0]    idx;
  logic          tc;

  logic [3:0] snap_su;
  logic [2:0] snap_st;
  logic [3:0] snap_mu;
  logic [2:0] snap_mt;

  logic [3:0] digit;
  logic       digit_ok;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign tc = (rc == RC_MAX);

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Snapshot loads with the 3->0 wrap so a frame never mixes two counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc      <= '0;
      idx     <= '0;
      snap_su <= '0;
      snap_st <= '0;
      snap_mu <= '0;
      snap_mt <= '0;
    end else begin
      rc <= tc ? '0 : rc + RW'(1);
      if (tc) idx <= idx + 2'd1;
      if (tc && idx == 2'd3) begin
        snap_su <= secUnits;
        snap_st <= secTens;
        snap_mu <= minUnits;
        snap_mt <= minTens;
      end
    end
  end

  // Tens digits are legal only up to 5; units up to 9.
  always_comb begin
    digit    = '0;
    digit_ok = 1'b0;
    unique case (idx)
      2'd0: begin
        digit    = snap_su;
        digit_ok = (snap_su <= 4'd9);
      end
      2'd1: begin
        digit    = {1'b0, snap_st};
        digit_ok = (snap_st <= 3'd5);
      end
      2'd2: begin
        digit    = snap_mu;
        digit_ok = (snap_mu <= 4'd9);
      end
      2'd3: begin
        digit    = {1'b0, snap_mt};
        digit_ok = (snap_mt <= 3'd5);
      end
    endcase
  end

  always_comb begin
    seg_nxt = digit_ok ? dec7(digit) : 7'b1111111;
    an_nxt  = ~(4'b0001 << idx);
    if (blank || (idx == 2'd3 && lz_blank && snap_mt == 3'd0))
      an_nxt = 4'b1111;
    dp_nxt  = ~((idx == 2'd2) && !blank);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_sec_min_display_mux.sv
// Scoreboard bench for sec_min_display_mux (REFRESH_DIV=4, 16-clk frames).
// Expectations are tagged with the post-reset cycle they must appear on.
module tb_sec_min_display_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] secUnits;
  logic [2:0] secTens;
  logic [3:0] minUnits;
  logic [2:0] minTens;
  logic       blank;
  logic       lz_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  sec_min_display_mux #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .secUnits (secUnits),
    .secTens  (secTens),
    .minUnits (minUnits),
    .minTens  (minTens),
    .blank    (blank),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Monitor: one expectation per cycle, matched by cycle tag.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      if (q[0].cyc == cyc) begin
        e = q.pop_front();
        checks++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          errors++;
          $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                   e.name, cyc, an, seg, dp, e.an, e.seg, e.dp);
        end
      end else if (q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end
    end
  end

  task automatic push(input int c, input logic [3:0] a,
                      input logic [6:0] s, input logic d,
                      input string nm);
    exp_t x;
    x.cyc = c; x.an = a; x.seg = s; x.dp = d; x.name = nm;
    q.push_back(x);
  endtask

  task automatic set_in(input logic [2:0] mt, input logic [3:0] mu,
                        input logic [2:0] st, input logic [3:0] su);
    minTens = mt; minUnits = mu; secTens = st; secUnits = su;
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc timeout want=%0d got=%0d", n, cyc);
    end
  endtask

  logic [3:0] an_t  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg59 [4] = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010};

  initial begin
    reset = 1'b1; blank = 1'b0; lz_blank = 1'b0;
    set_in(3'd1, 4'd2, 3'd3, 4'd4);
    for (int i = 0; i < 3; i++) push(0, 4'b1111, 7'b1111111, 1'b1, "rst1");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // frame 0 shows cleared snapshot, frame 1 shows 12:34
    push(1,  4'b1110, 7'b1000000, 1'b1, "t1_first");
    push(9,  4'b1011, 7'b1000000, 1'b0, "t1_f0d2");
    push(13, 4'b0111, 7'b1000000, 1'b1, "t1_f0d3");
    push(17, 4'b1110, 7'b0011001, 1'b1, "t1_f1d0");
    push(21, 4'b1101, 7'b0110000, 1'b1, "t1_f1d1");
    push(25, 4'b1011, 7'b0100100, 1'b0, "t1_f1d2");
    push(29, 4'b0111, 7'b1111001, 1'b1, "t1_f1d3");

    wait_cyc(30);
    set_in(3'd5, 4'd9, 3'd5, 4'd9);
    for (int k = 0; k < 16; k++)
      push(33 + k, an_t[k/4], seg59[k/4], (k/4 == 2) ? 1'b0 : 1'b1, "t2_scan");

    wait_cyc(46);
    set_in(3'd0, 4'd0, 3'd0, 4'd7);
    push(49, 4'b1110, 7'b1111000, 1'b1, "t3_d0a");
    push(52, 4'b1110, 7'b1111000, 1'b1, "t3_d0b");
    push(55, 4'b1101, 7'b1000000, 1'b1, "t3_d1");
    push(57, 4'b1011, 7'b1000000, 1'b0, "t3_d2");
    push(64, 4'b0111, 7'b1000000, 1'b1, "t3_d3");
    push(65, 4'b1110, 7'b0000000, 1'b1, "t3_new8a");
    push(68, 4'b1110, 7'b0000000, 1'b1, "t3_new8b");
    wait_cyc(54);
    set_in(3'd0, 4'd0, 3'd0, 4'd8);

    wait_cyc(70);
    set_in(3'd0, 4'd5, 3'd0, 4'd0);
    lz_blank = 1'b1;
    push(81,  4'b1110, 7'b1000000, 1'b1, "t4_d0");
    push(89,  4'b1011, 7'b0010010, 1'b0, "t4_d2");
    push(93,  4'b1111, 7'b1000000, 1'b1, "t4_lz_a");
    push(94,  4'b1111, 7'b1000000, 1'b1, "t4_lz_b");
    push(95,  4'b0111, 7'b1000000, 1'b1, "t4_lz_off");
    push(109, 4'b0111, 7'b1000000, 1'b1, "t4_lz_off2");
    wait_cyc(94);
    lz_blank = 1'b0;

    wait_cyc(110);
    blank = 1'b1;
    push(111, 4'b1111, 7'b1000000, 1'b1, "t5_blk_a");
    push(113, 4'b1111, 7'b1000000, 1'b1, "t5_blk_b");
    push(121, 4'b1111, 7'b0010010, 1'b1, "t5_blk_dp");
    push(130, 4'b1111, 7'b1000000, 1'b1, "t5_blk_end");
    push(131, 4'b1110, 7'b1000000, 1'b1, "t5_resume");
    push(133, 4'b1101, 7'b1000000, 1'b1, "t5_d1");
    push(137, 4'b1011, 7'b0010010, 1'b0, "t5_d2");
    wait_cyc(130);
    blank = 1'b0;

    wait_cyc(140);
    set_in(3'd2, 4'd3, 3'd4, 4'd1);
    push(145, 4'b1110, 7'b1111001, 1'b1, "t6_d0");
    push(153, 4'b1011, 7'b0110000, 1'b0, "t6_d2");

    // idx=2, rc=1 here
    wait_cyc(153);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL t6_drain left=%0d", q.size());
      q.delete();
    end
    reset = 1'b1;
    push(0, 4'b1111, 7'b1111111, 1'b1, "t6_rst_a");
    push(0, 4'b1111, 7'b1111111, 1'b1, "t6_rst_b");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(1,  4'b1110, 7'b1000000, 1'b1, "t6_r1");
    push(4,  4'b1110, 7'b1000000, 1'b1, "t6_r4");
    push(5,  4'b1101, 7'b1000000, 1'b1, "t6_r5");
    push(9,  4'b1011, 7'b1000000, 1'b0, "t6_r9");
    push(13, 4'b0111, 7'b1000000, 1'b1, "t6_r13");
    push(17, 4'b1110, 7'b1111001, 1'b1, "t6_r17");
    push(29, 4'b0111, 7'b0100100, 1'b1, "t6_r29");

    wait_cyc(30);
    set_in(3'd7, 4'd15, 3'd6, 4'd10);
    push(33, 4'b1110, 7'b1111111, 1'b1, "t7_bad_su");
    push(37, 4'b1101, 7'b1111111, 1'b1, "t7_bad_st");
    push(41, 4'b1011, 7'b1111111, 1'b0, "t7_bad_mu");
    push(45, 4'b0111, 7'b1111111, 1'b1, "t7_bad_mt");

    wait_cyc(46);
    set_in(3'd4, 4'd6, 3'd2, 4'd6);
    push(49, 4'b1110, 7'b0000010, 1'b1, "t8_six_u");
    push(53, 4'b1101, 7'b0100100, 1'b1, "t8_two");
    push(57, 4'b1011, 7'b0000010, 1'b0, "t8_six_m");
    push(61, 4'b0111, 7'b0011001, 1'b1, "t8_four");

    wait_cyc(64);
    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      errors++;
      $display("FAIL %s never_checked cyc=%0d", e.name, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
